// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix datapath blocks: FSM state type,
// default element width and a counter-width helper.
package matrix_pkg;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int unsigned MATRIX_W = 3;

  // Minimum of 1 bit so N=2 still gets a usable counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) index pair over an NxN matrix; col is the fast index.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [clog2(N)-1:0] row,
  output logic [clog2(N)-1:0] col,
  output logic                at_last
);

  localparam int unsigned      CW   = clog2(N);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_comb at_last = (row == LAST) && (col == LAST);

endmodule

// File: rtl/matrix_transpose_stream.sv
// Streaming NxN transposer: loads a matrix row-major into a register array,
// then drains it row-major either transposed or unchanged.
module matrix_transpose_stream
  import matrix_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = MATRIX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         mode_transpose,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned CW = clog2(N);

  state_t        state;
  logic          mode_q;
  logic          busy_q;
  logic [W-1:0]  mem [N][N];
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic          at_last;
  logic          in_hs;
  logic          out_hs;

  matrix_index_counter #(.N(N)) u_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (in_hs | out_hs),
    .clr     (flush),
    .row     (row),
    .col     (col),
    .at_last (at_last)
  );

  // flush gates both handshakes in the same cycle it is asserted.
  always_comb begin
    in_ready  = (state == ST_LOAD) && !flush;
    out_valid = (state == ST_DRAIN) && !flush;
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    out_last  = (state == ST_DRAIN) && at_last;
    busy      = busy_q || in_hs;
    out_data  = mode_q ? mem[col][row] : mem[row][col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      mode_q <= 1'b0;
      busy_q <= 1'b0;
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned c = 0; c < N; c++)
          mem[r][c] <= '0;
    end else if (flush) begin
      state  <= ST_LOAD;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_hs) begin
            mem[row][col] <= in_data;
            busy_q        <= 1'b1;
            if (row == '0 && col == '0) mode_q <= mode_transpose;
            if (at_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_hs && at_last) begin
            state  <= ST_LOAD;
            busy_q <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
